// File: rtl/noc_arb_pkg.sv
// Shared definitions for the mesh-router output-port arbiter: port indices,
// FSM encoding and the rotating-priority pick used by the arbiter and VC allocator.
package noc_arb_pkg;

    localparam int NUM_PORTS = 5;
    localparam int IDX_W     = 3;

    localparam int P_N = 0;
    localparam int P_S = 1;
    localparam int P_E = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    localparam int TAIL_BIT = 46;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // One-hot pick of the first set request at ptr, ptr+1, ... (mod NUM_PORTS).
    function automatic logic [NUM_PORTS-1:0] rr_onehot(input logic [NUM_PORTS-1:0] req,
                                                       input logic [IDX_W-1:0]     ptr);
        logic [NUM_PORTS-1:0] pick;
        int                   idx;
        pick = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_PORTS - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational rotating-priority encoder: one-hot winner and its index,
// searching from rr_ptr upward with wrap. Index is 0 when nothing requests.
module noc_rr_pick
    import noc_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] pick_oh,
    output logic [IDX_W-1:0]     pick_idx
);

    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        pick_oh  = rr_onehot(req, rr_ptr);
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Per-output-port wormhole arbiter with round-robin fairness and credit gating.
// Optional starvation guard enabled by defining NOC_ARB_STARVE_GUARD_EN.
module noc_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
`ifdef NOC_ARB_STARVE_GUARD_EN
   ,parameter int STARVE_LIMIT = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_last,
    input  logic               credit_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               fire,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               locked,
    output logic [CRED_W-1:0]  credit_level,
    output logic [31:0]        stall_arb_count,
    output logic [31:0]        stall_cred_count,
    output logic [31:0]        pkt_count
`ifdef NOC_ARB_STARVE_GUARD_EN
   ,output logic [31:0]        starve_count
`endif
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0]  credit_q, credit_d;
    logic [31:0]        arb_cnt_q, arb_cnt_d;
    logic [31:0]        cred_cnt_q, cred_cnt_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;

    logic [NUM_REQ-1:0] rr_oh, win_oh;
    logic [IDX_W-1:0]   rr_idx, win_idx;
    logic               cred_ok, tail, pkt_done, eligible;

    noc_rr_pick u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .pick_oh  (rr_oh),
        .pick_idx (rr_idx)
    );

`ifdef NOC_ARB_STARVE_GUARD_EN
    logic [4:0]         wait_q [NUM_REQ];
    logic [4:0]         wait_d [NUM_REQ];
    logic [31:0]        starve_cnt_q, starve_cnt_d;
    logic               forced;

    // A long-waiting requester overrides round-robin; the lowest index wins ties.
    always_comb begin
        forced  = 1'b0;
        win_oh  = rr_oh;
        win_idx = rr_idx;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && int'(wait_q[i]) >= STARVE_LIMIT) begin
                forced     = 1'b1;
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_idx    = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (grant[i])                        wait_d[i] = '0;
            else if (req[i] && wait_q[i] != '1)  wait_d[i] = wait_q[i] + 5'd1;
        end
        starve_cnt_d = (forced && fire && state_q == ST_IDLE) ? sat_add(starve_cnt_q, 32'd1)
                                                              : starve_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
            starve_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_count = starve_cnt_q;
`else
    always_comb begin
        win_oh  = rr_oh;
        win_idx = rr_idx;
    end
`endif

    assign cred_ok = (credit_q != '0);

    // Output process: grant is combinational from registered state and req.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (cred_ok) begin
            if (state_q == ST_IDLE) begin
                grant     = win_oh;
                grant_idx = (|win_oh) ? win_idx : '0;
            end else begin
                grant[owner_q] = req[owner_q];
                grant_idx      = req[owner_q] ? owner_q : '0;
            end
        end
    end

    assign fire = |(grant & req);
    assign tail = |(grant & req_last);

    // Next-state process: packet lock and round-robin pointer advance.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        pkt_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    if (tail) begin
                        pkt_done = 1'b1;
                        rr_ptr_d = next_idx(win_idx);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (fire && tail) begin
                    state_d  = ST_IDLE;
                    pkt_done = 1'b1;
                    rr_ptr_d = next_idx(owner_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (fire && !credit_in)
            credit_d = credit_q - CRED_W'(1);
        else if (credit_in && !fire && credit_q != CRED_W'(CREDITS))
            credit_d = credit_q + CRED_W'(1);

        eligible   = (state_q == ST_LOCKED) ? req[owner_q] : |req;
        arb_cnt_d  = cred_ok ? sat_add(arb_cnt_q, 32'($countones(req & ~grant))) : arb_cnt_q;
        cred_cnt_d = (!cred_ok && eligible) ? sat_add(cred_cnt_q, 32'd1) : cred_cnt_q;
        pkt_cnt_d  = pkt_done ? sat_add(pkt_cnt_q, 32'd1) : pkt_cnt_q;
    end

    // State register process.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= CRED_W'(CREDITS);
            arb_cnt_q  <= '0;
            cred_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= credit_d;
            arb_cnt_q  <= arb_cnt_d;
            cred_cnt_q <= cred_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign locked           = (state_q == ST_LOCKED);
    assign credit_level     = credit_q;
    assign stall_arb_count  = arb_cnt_q;
    assign stall_cred_count = cred_cnt_q;
    assign pkt_count        = pkt_cnt_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: directed scenarios plus random
// traffic, compared every cycle against an integer-level behavioural model.
module tb_noc_port_arbiter;

    localparam int N       = 5;
    localparam int CREDITS = 4;
    localparam int CRED_W  = 3;
`ifdef NOC_ARB_STARVE_GUARD_EN
    localparam int STARVE_LIMIT = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, req_last;
    logic              credit_in;
    logic [N-1:0]      grant;
    logic              fire;
    logic [2:0]        grant_idx;
    logic              locked;
    logic [CRED_W-1:0] credit_level;
    logic [31:0]       stall_arb_count, stall_cred_count, pkt_count;
`ifdef NOC_ARB_STARVE_GUARD_EN
    logic [31:0]       starve_count;
`endif

    noc_port_arbiter #(
        .NUM_REQ (N),
        .CREDITS (CREDITS),
        .CRED_W  (CRED_W)
`ifdef NOC_ARB_STARVE_GUARD_EN
       ,.STARVE_LIMIT (STARVE_LIMIT)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_last         (req_last),
        .credit_in        (credit_in),
        .grant            (grant),
        .fire             (fire),
        .grant_idx        (grant_idx),
        .locked           (locked),
        .credit_level     (credit_level),
        .stall_arb_count  (stall_arb_count),
        .stall_cred_count (stall_cred_count),
        .pkt_count        (pkt_count)
`ifdef NOC_ARB_STARVE_GUARD_EN
       ,.starve_count     (starve_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    bit      m_locked;
    int      m_owner, m_ptr, m_cred;
    longint  m_arb, m_cst, m_pkt, m_starve;
    int      m_wait [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cred   = CREDITS;
        m_arb    = 0;
        m_cst    = 0;
        m_pkt    = 0;
        m_starve = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endfunction

    // Entered at a negedge: drive inputs, check outputs, advance the model, return at the next negedge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic cin);
        int           win;
        bit           forced;
        logic [N-1:0] g;
        req       = r;
        req_last  = l;
        credit_in = cin;
        #1;
        win    = -1;
        forced = 1'b0;
        if (m_cred > 0) begin
            if (m_locked) begin
                if (r[m_owner]) win = m_owner;
            end else begin
`ifdef NOC_ARB_STARVE_GUARD_EN
                for (int i = 0; i < N; i++)
                    if (win < 0 && r[i] && m_wait[i] >= STARVE_LIMIT) begin
                        win    = i;
                        forced = 1'b1;
                    end
`endif
                for (int k = 0; k < N; k++)
                    if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        g = '0;
        if (win >= 0) g[win] = 1'b1;

        check("grant",            32'(grant),            32'(g));
        check("fire",             32'(fire),             32'(win >= 0));
        check("grant_idx",        32'(grant_idx),        (win >= 0) ? 32'(win) : 32'd0);
        check("locked",           32'(locked),           32'(m_locked));
        check("credit_level",     32'(credit_level),     32'(m_cred));
        check("stall_arb_count",  stall_arb_count,       32'(m_arb));
        check("stall_cred_count", stall_cred_count,      32'(m_cst));
        check("pkt_count",        pkt_count,             32'(m_pkt));
`ifdef NOC_ARB_STARVE_GUARD_EN
        check("starve_count",     starve_count,          32'(m_starve));
`endif

        if (m_cred > 0) m_arb += $countones(r & ~g);
        else if (m_locked ? r[m_owner] : (r != '0)) m_cst++;
`ifdef NOC_ARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++) begin
            if (i == win)                    m_wait[i] = 0;
            else if (r[i] && m_wait[i] < 31) m_wait[i]++;
        end
        if (forced) m_starve++;
`endif
        if (win >= 0) begin
            if (!m_locked) begin
                if (l[win]) begin
                    m_pkt++;
                    m_ptr = (win + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = win;
                end
            end else if (l[win]) begin
                m_locked = 1'b0;
                m_pkt++;
                m_ptr = (m_owner + 1) % N;
            end
        end
        if (win >= 0 && !cin)                      m_cred--;
        else if (win < 0 && cin && m_cred < CREDITS) m_cred++;
        @(negedge clk);
    endtask

    // Entered at a negedge: one reset edge with the given requests held, then release.
    task automatic do_reset(input logic [N-1:0] r);
        reset     = 1'b1;
        req       = r;
        req_last  = '0;
        credit_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_last  = '0;
        credit_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset state, then three single-flit packets from N, S, E.
        step(5'b00000, 5'b00000, 1'b0);
        repeat (3) step(5'b00111, 5'b11111, 1'b1);

        // N sends a 3-flit packet while S waits; S follows.
        step(5'b00011, 5'b00000, 1'b1);
        step(5'b00011, 5'b00000, 1'b1);
        step(5'b00011, 5'b00001, 1'b1);
        step(5'b00010, 5'b00010, 1'b1);
        step(5'b00000, 5'b00000, 1'b0);

        // Credit exhaustion by Local, then one credit releases exactly one flit.
        do_reset(5'b00000);
        repeat (6) step(5'b10000, 5'b10000, 1'b0);
        step(5'b10000, 5'b10000, 1'b1);
        step(5'b10000, 5'b10000, 1'b0);
        step(5'b10000, 5'b10000, 1'b0);

        // Simultaneous fire and credit at level 2; credit saturation at CREDITS.
        do_reset(5'b00000);
        step(5'b10000, 5'b10000, 1'b0);
        step(5'b10000, 5'b10000, 1'b0);
        step(5'b10000, 5'b10000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b0);

        // Reset mid-packet while W owns the port; E wins right after.
        do_reset(5'b00000);
        step(5'b01000, 5'b00000, 1'b1);
        step(5'b01100, 5'b00000, 1'b1);
        do_reset(5'b01100);
        step(5'b00100, 5'b00100, 1'b0);
        step(5'b00000, 5'b00000, 1'b0);

`ifdef NOC_ARB_STARVE_GUARD_EN
        // E starved behind a 4-flit N packet; it then beats S although rr_ptr points at S.
        do_reset(5'b00000);
        step(5'b00101, 5'b00000, 1'b1);
        step(5'b00101, 5'b00000, 1'b1);
        step(5'b00101, 5'b00000, 1'b1);
        step(5'b00101, 5'b00001, 1'b1);
        step(5'b00110, 5'b00100, 1'b1);
        step(5'b00010, 5'b00010, 1'b1);
        step(5'b00000, 5'b00000, 1'b0);
`endif

        // Random traffic, including credit starvation and mid-packet bubbles.
        do_reset(5'b00000);
        for (int n = 0; n < 400; n++) begin
            step(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
